// File: rtl/sc_regdeserializer.sv
// Serial-to-parallel receiver for the register-load path. It assembles framed bits into a word
// and emits active-low load/clear strobes that are compatible with SC_RegGENERAL.
module sc_regdeserializer #(
  parameter int DATAWIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           SC_REGDESERIALIZER_CLOCK_50,
  input  logic                           SC_REGDESERIALIZER_RESET_InHigh,
  input  logic                           SC_REGDESERIALIZER_frame_InLow,
  input  logic                           SC_REGDESERIALIZER_valid_InLow,
  input  logic                           SC_REGDESERIALIZER_serial_In,
  output logic [DATAWIDTH-1:0]           SC_REGDESERIALIZER_data_OutBUS,
  output logic                           SC_REGDESERIALIZER_load_OutLow,
  output logic                           SC_REGDESERIALIZER_clear_OutLow,
  output logic                           SC_REGDESERIALIZER_busy_Out,
  output logic [$clog2(DATAWIDTH+1)-1:0] SC_REGDESERIALIZER_count_OutBUS
);

  localparam int CW = $clog2(DATAWIDTH+1);

  typedef enum logic [1:0] {IDLE, SHIFT, ABORT} stateType;

  stateType             state;
  logic [DATAWIDTH-1:0] shiftReg;
  logic [CW-1:0]        count;
  logic [DATAWIDTH-1:0] shiftedWord;
  logic                 sampleBit;
  logic                 lastBit;

  // A frame close always wins over a simultaneous valid bit.
  always_comb begin
    sampleBit = (state != ABORT) && !SC_REGDESERIALIZER_frame_InLow
                && !SC_REGDESERIALIZER_valid_InLow;
    lastBit   = (count == CW'(DATAWIDTH-1));
    if (MSB_FIRST)
      shiftedWord = {shiftReg[DATAWIDTH-2:0], SC_REGDESERIALIZER_serial_In};
    else
      shiftedWord = {SC_REGDESERIALIZER_serial_In, shiftReg[DATAWIDTH-1:1]};
  end

  assign SC_REGDESERIALIZER_count_OutBUS = count;

  always_ff @(posedge SC_REGDESERIALIZER_CLOCK_50) begin
    if (SC_REGDESERIALIZER_RESET_InHigh) begin
      state                           <= IDLE;
      shiftReg                        <= '0;
      count                           <= '0;
      SC_REGDESERIALIZER_data_OutBUS  <= '0;
      SC_REGDESERIALIZER_load_OutLow  <= 1'b1;
      SC_REGDESERIALIZER_clear_OutLow <= 1'b1;
      SC_REGDESERIALIZER_busy_Out     <= 1'b0;
    end else begin
      SC_REGDESERIALIZER_load_OutLow  <= 1'b1;
      SC_REGDESERIALIZER_clear_OutLow <= 1'b1;
      case (state)
        IDLE: begin
          if (!SC_REGDESERIALIZER_frame_InLow) begin
            state                       <= SHIFT;
            SC_REGDESERIALIZER_busy_Out <= 1'b1;
          end
        end
        SHIFT: begin
          if (SC_REGDESERIALIZER_frame_InLow) begin
            shiftReg <= '0;
            count    <= '0;
            if (count == '0) begin
              state                       <= IDLE;
              SC_REGDESERIALIZER_busy_Out <= 1'b0;
            end else begin
              state                           <= ABORT;
              SC_REGDESERIALIZER_clear_OutLow <= 1'b0;
            end
          end
        end
        ABORT: begin
          state                       <= IDLE;
          SC_REGDESERIALIZER_busy_Out <= 1'b0;
        end
        default: begin
          state                       <= IDLE;
          SC_REGDESERIALIZER_busy_Out <= 1'b0;
        end
      endcase
      // The word completes on its last bit, so count wraps to zero and never reads DATAWIDTH.
      if (sampleBit) begin
        if (lastBit) begin
          SC_REGDESERIALIZER_data_OutBUS <= shiftedWord;
          SC_REGDESERIALIZER_load_OutLow <= 1'b0;
          shiftReg                       <= '0;
          count                          <= '0;
        end else begin
          shiftReg <= shiftedWord;
          count    <= count + CW'(1);
        end
      end
    end
  end

endmodule
